branch_predictor_ctrl: RTL and testbench

BRANCH_PREDICTOR_CTRL -- requirements
Module: branch_predictor_ctrl

---
 rtl/bp_pkg.sv | 21 ++
 rtl/bp_sat_counter.sv | 21 ++
 rtl/branch_predictor_ctrl.sv | 111 +++++++++++
 tb/tb_branch_predictor_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared branch-predictor types: 2-bit counter states and the per-index table entry.
// Pure declarations, no latency; no flow control.
// Consumed by bp_sat_counter and branch_predictor_ctrl.
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Tag is held zero-extended to 30 bits so the struct is independent of ENTRIES.
    typedef struct packed {
        logic [1:0]  ctr;
        logic        valid;
        logic [29:0] tag;
        logic [29:0] target;
    } bp_entry_t;

    localparam bp_entry_t BP_ENTRY_RESET = '{ctr: WNT, valid: 1'b0, tag: '0, target: '0};

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating counter next-state logic.
// Combinational, zero latency.
// No backpressure; evaluated every cycle, caller decides whether to commit.
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic [1:0] curState,
    input  logic       taken,
    output logic [1:0] nextState
);

    always_comb begin
        nextState = curState;
        if (taken) begin
            if (curState != ST) nextState = curState + 2'd1;
        end else begin
            if (curState != SNT) nextState = curState - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor_ctrl.sv
// Bimodal BHT + direct-mapped BTB with EX-stage resolution; define GSHARE_EN for gshare BHT indexing.
// Lookup is combinational (zero cycles); updates commit on the falling edge of Clk.
// No backpressure: one lookup and at most one resolved branch accepted every cycle.
module branch_predictor_ctrl
    import bp_pkg::*;
#(
    parameter int ENTRIES   = 16,
    parameter int HIST_BITS = 4
)
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] IF_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        EX_valid,
    input  logic [31:0] EX_pc,
    input  logic [31:0] EX_target,
    input  logic        EX_taken,
    input  logic        EX_pred_taken,
    input  logic [31:0] EX_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int IDXW = $clog2(ENTRIES);

    if (ENTRIES < 4 || ENTRIES > 256 || (1 << IDXW) != ENTRIES) begin : gBadEntries
        $error("ENTRIES must be a power of two in 4..256");
    end
    if (HIST_BITS < 1 || HIST_BITS > IDXW) begin : gBadHist
        $error("HIST_BITS must be in 1..log2(ENTRIES)");
    end

    bp_entry_t [ENTRIES-1:0] entryTable;
    logic [31:0]             branchCnt;
    logic [31:0]             mispredCnt;

    logic [IDXW-1:0] ifIdx, exIdx, ifBhtIdx, exBhtIdx;
    logic [29:0]     ifTag, exTag;
    logic            ifHit;
    logic [1:0]      ctrNext;

    assign ifIdx = IF_pc[IDXW+1:2];
    assign exIdx = EX_pc[IDXW+1:2];
    assign ifTag = 30'(IF_pc[31:IDXW+2]);
    assign exTag = 30'(EX_pc[31:IDXW+2]);

`ifdef GSHARE_EN
    // History tracks resolved outcomes only, so it never needs repair after a flush.
    logic [HIST_BITS-1:0] globalHist;

    always_ff @(negedge Clk or posedge Rst) begin
        if (Rst) begin
            globalHist <= '0;
        end else if (EX_valid) begin
            globalHist <= HIST_BITS'({globalHist, EX_taken});
        end
    end

    assign ifBhtIdx = ifIdx ^ IDXW'(globalHist);
    assign exBhtIdx = exIdx ^ IDXW'(globalHist);
`else
    assign ifBhtIdx = ifIdx;
    assign exBhtIdx = exIdx;
`endif

    // Reads see the table as it stood before this cycle's falling-edge write.
    assign ifHit       = entryTable[ifIdx].valid && (entryTable[ifIdx].tag == ifTag);
    assign pred_taken  = !Rst && entryTable[ifBhtIdx].ctr[1] && ifHit;
    assign pred_target = pred_taken ? {entryTable[ifIdx].target, 2'b00} : IF_pc + 32'd4;

    assign mispredict  = !Rst && EX_valid &&
                         ((EX_taken != EX_pred_taken) ||
                          (EX_taken && (EX_pred_target != EX_target)));
    assign redirect_pc = !mispredict ? 32'd0 :
                         EX_taken    ? EX_target : EX_pc + 32'd4;

    bp_sat_counter uSatCounter (
        .curState  (entryTable[exBhtIdx].ctr),
        .taken     (EX_taken),
        .nextState (ctrNext)
    );

    always_ff @(negedge Clk or posedge Rst) begin
        if (Rst) begin
            entryTable <= {ENTRIES{BP_ENTRY_RESET}};
            branchCnt  <= '0;
            mispredCnt <= '0;
        end else begin
            if (EX_valid) begin
                entryTable[exBhtIdx].ctr <= ctrNext;
                if (EX_taken) begin
                    entryTable[exIdx].valid  <= 1'b1;
                    entryTable[exIdx].tag    <= exTag;
                    entryTable[exIdx].target <= EX_target[31:2];
                end
                if (branchCnt != 32'hFFFF_FFFF) branchCnt <= branchCnt + 32'd1;
            end
            if (mispredict && mispredCnt != 32'hFFFF_FFFF) begin
                mispredCnt <= mispredCnt + 32'd1;
            end
        end
    end

    assign branch_cnt  = branchCnt;
    assign mispred_cnt = mispredCnt;

endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// Self-checking bench for branch_predictor_ctrl (default ENTRIES=16, GSHARE_EN undefined).
// Inputs change just after the rising edge, outputs are checked before the falling (update) edge.
module tb_branch_predictor_ctrl;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] IF_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        EX_valid;
    logic [31:0] EX_pc;
    logic [31:0] EX_target;
    logic        EX_taken;
    logic        EX_pred_taken;
    logic [31:0] EX_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int passCnt  = 0;
    int totalCnt = 0;

    branch_predictor_ctrl #(.ENTRIES(16), .HIST_BITS(4)) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .IF_pc          (IF_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .EX_valid       (EX_valid),
        .EX_pc          (EX_pc),
        .EX_target      (EX_target),
        .EX_taken       (EX_taken),
        .EX_pred_taken  (EX_pred_taken),
        .EX_pred_target (EX_pred_target),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [31:0] ifPc;
        logic        exValid;
        logic [31:0] exPc;
        logic [31:0] exTarget;
        logic        exTaken;
        logic        exPredTaken;
        logic [31:0] exPredTarget;
        logic        expTaken;
        logic [31:0] expTarget;
        logic        expMis;
        logic [31:0] expRedirect;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];
    vec_t expQ [$];

    function automatic vec_t mk(input logic [31:0] ifPc, input logic exValid,
                                input logic [31:0] exPc, input logic [31:0] exTarget,
                                input logic exTaken, input logic exPredTaken,
                                input logic [31:0] exPredTarget, input logic expTaken,
                                input logic [31:0] expTarget, input logic expMis,
                                input logic [31:0] expRedirect);
        vec_t v;
        v.ifPc = ifPc;           v.exValid = exValid;
        v.exPc = exPc;           v.exTarget = exTarget;
        v.exTaken = exTaken;     v.exPredTaken = exPredTaken;
        v.exPredTarget = exPredTarget;
        v.expTaken = expTaken;   v.expTarget = expTarget;
        v.expMis = expMis;       v.expRedirect = expRedirect;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s #%0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
    endtask

    task automatic applyVec(input vec_t v, input int idx);
        vec_t e;
        @(posedge Clk);
        #1;
        IF_pc          = v.ifPc;
        EX_valid       = v.exValid;
        EX_pc          = v.exPc;
        EX_target      = v.exTarget;
        EX_taken       = v.exTaken;
        EX_pred_taken  = v.exPredTaken;
        EX_pred_target = v.exPredTarget;
        expQ.push_back(v);
        #2;
        e = expQ.pop_front();
        chk("pred_taken",  idx, {31'b0, pred_taken}, {31'b0, e.expTaken});
        chk("pred_target", idx, pred_target,         e.expTarget);
        chk("mispredict",  idx, {31'b0, mispredict}, {31'b0, e.expMis});
        chk("redirect_pc", idx, redirect_pc,         e.expRedirect);
    endtask

    localparam logic [31:0] PA = 32'h0040_0020, TA = 32'h0040_0100;
    localparam logic [31:0] PB = 32'h0040_0080, TB = 32'h0040_1000;
    localparam logic [31:0] PC = 32'h0000_0010;

    initial begin
        int expBr;
        int expMis;
        expBr  = 0;
        expMis = 0;

        //           IF_pc          ev  EX_pc          EX_target      tk pt predTgt        expPT expTgt         mis redirect
        vecs[0]  = mk(32'h0040_0010, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 32'h0040_0014, 0, 32'h0);
        vecs[1]  = mk(32'h0040_0040, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 32'h0040_0044, 0, 32'h0);
        vecs[2]  = mk(PA,            1, PA,           TA,           1, 0, 32'h0040_0024, 0, 32'h0040_0024, 1, TA);
        vecs[3]  = mk(PA,            1, PA,           TA,           1, 0, 32'h0040_0024, 1, TA,           1, TA);
        vecs[4]  = mk(PA,            0, 32'h0,        32'h0,        0, 0, 32'h0,        1, TA,           0, 32'h0);
        vecs[5]  = mk(32'h0040_0060, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 32'h0040_0064, 0, 32'h0);
        vecs[6]  = mk(PB,            1, PB,           TB,           1, 0, 32'h0040_0084, 0, 32'h0040_0084, 1, TB);
        vecs[7]  = mk(PB,            1, PB,           TB,           1, 1, TB,           1, TB,           0, 32'h0);
        vecs[8]  = mk(PB,            1, PB,           TB,           1, 1, TB,           1, TB,           0, 32'h0);
        vecs[9]  = mk(PB,            1, PB,           TB,           1, 1, TB,           1, TB,           0, 32'h0);
        vecs[10] = mk(PB,            1, PB,           TB,           1, 1, TB,           1, TB,           0, 32'h0);
        vecs[11] = mk(PB,            1, PB,           TB,           0, 1, TB,           1, TB,           1, 32'h0040_0084);
        vecs[12] = mk(PB,            1, PB,           TB,           0, 1, TB,           1, TB,           1, 32'h0040_0084);
        vecs[13] = mk(PB,            0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 32'h0040_0084, 0, 32'h0);
        vecs[14] = mk(PC,            1, PC,           32'h0000_0200, 1, 1, 32'h0000_0100, 0, 32'h0000_0014, 1, 32'h0000_0200);
        vecs[15] = mk(PC,            0, 32'h0,        32'h0,        0, 0, 32'h0,        1, 32'h0000_0200, 0, 32'h0);
        vecs[16] = mk(32'h0040_0030, 0, 32'h0040_0030, 32'h0040_0300, 1, 0, 32'h0,       0, 32'h0040_0034, 0, 32'h0);
        vecs[17] = mk(32'h0040_0030, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 32'h0040_0034, 0, 32'h0);
        vecs[18] = mk(32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h0000_0040, 0, 1, 32'h0000_0040, 0, 32'h0000_0000, 1, 32'h0);

        // Reset held across falling edges while a taken branch is presented: nothing may be learned.
        Rst            = 1'b1;
        IF_pc          = 32'h0040_0010;
        EX_valid       = 1'b1;
        EX_pc          = 32'h0040_0040;
        EX_target      = 32'h0040_0200;
        EX_taken       = 1'b1;
        EX_pred_taken  = 1'b0;
        EX_pred_target = 32'h0;
        @(posedge Clk);
        #3;
        chk("rst_pred_taken",  0, {31'b0, pred_taken}, 32'h0);
        chk("rst_pred_target", 0, pred_target,         32'h0040_0014);
        chk("rst_mispredict",  0, {31'b0, mispredict}, 32'h0);
        chk("rst_redirect_pc", 0, redirect_pc,         32'h0);
        repeat (2) @(negedge Clk);
        @(posedge Clk);
        #1;
        Rst      = 1'b0;
        EX_valid = 1'b0;
        #2;
        chk("post_rst_pred_taken",  0, {31'b0, pred_taken}, 32'h0);
        chk("post_rst_pred_target", 0, pred_target,         32'h0040_0014);
        chk("post_rst_branch_cnt",  0, branch_cnt,          32'h0);
        chk("post_rst_mispred_cnt", 0, mispred_cnt,         32'h0);

        for (int i = 0; i < NVEC; i++) begin
            applyVec(vecs[i], i);
            if (vecs[i].exValid) expBr++;
            if (vecs[i].expMis)  expMis++;
        end

        @(negedge Clk);
        #1;
        chk("branch_cnt",  NVEC, branch_cnt,  32'(expBr));
        chk("mispred_cnt", NVEC, mispred_cnt, 32'(expMis));

        // Mid-run reset clears learned state and statistics.
        Rst = 1'b1;
        #1;
        chk("rerst_pred_taken", 0, {31'b0, pred_taken}, 32'h0);
        chk("rerst_branch_cnt", 0, branch_cnt,          32'h0);
        @(posedge Clk);
        #1;
        Rst   = 1'b0;
        IF_pc = PA;
        #2;
        chk("rerst_lookup_taken",  0, {31'b0, pred_taken}, 32'h0);
        chk("rerst_lookup_target", 0, pred_target,         32'h0040_0024);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
